// File: rtl/input_block_pkg.sv
// Shared definitions for the switch/button entry front end: FSM encoding and debounce default.
package input_block_pkg;

    typedef enum logic [1:0] {
        S_LO    = 2'd0,
        S_HI    = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam int DB_TICKS_DEFAULT = 10;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchronizer, tick-driven stability counter, one-cycle press pulse.
module btn_debounce #(
    parameter int DB_TICKS = 10
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iTick,
    input  logic iB,
    output logic oLevel,
    output logic oPress
);

    localparam int CW = (DB_TICKS > 2) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DB_TICKS - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic          press_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            press_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            sync1_reg <= iB;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (iTick) begin
                // Any tick that agrees with the stable level restarts the run.
                if (sync2_reg != stable_reg) begin
                    if (count_reg == COUNT_MAX) begin
                        stable_reg <= sync2_reg;
                        count_reg  <= '0;
                        press_reg  <= sync2_reg;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end else begin
                    count_reg <= '0;
                end
            end
        end
    end

    assign oLevel = stable_reg;
    assign oPress = press_reg;

endmodule

// File: rtl/input_block.sv
// Two-half 32-bit word entry from slide switches with load/clear buttons and a valid/ack handshake.
// Optional echo output to the display mux is enabled by defining INPUT_BLOCK_ECHO_EN.
module input_block
    import input_block_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iTick,
    input  logic [15:0] iSw,
    input  logic        iBLoad,
    input  logic        iBClr,
    input  logic        iAck,
    output logic [31:0] oData,
    output logic        oValid,
    output logic        oHalf
`ifdef INPUT_BLOCK_ECHO_EN
    ,
    output logic [15:0] oEcho
`endif
);

    logic [1:0] btn_raw;
    logic [1:0] btn_press;
    logic [1:0] level_unused;

    assign btn_raw = {iBClr, iBLoad};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DB_TICKS(DB_TICKS)
            ) u_btn (
                .iClk  (iClk),
                .iRstN (iRstN),
                .iTick (iTick),
                .iB    (btn_raw[gi]),
                .oLevel(level_unused[gi]),
                .oPress(btn_press[gi])
            );
        end
    endgenerate

    logic load_press;
    logic clr_press;

    assign load_press = btn_press[0];
    assign clr_press  = btn_press[1];

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] data_reg;
    logic [31:0] data_next;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_reg <= S_LO;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        // Clear overrides any load or ack arriving in the same cycle.
        if (clr_press) begin
            state_next = S_LO;
            data_next  = '0;
        end else begin
            case (state_reg)
                S_LO: begin
                    if (load_press) begin
                        data_next[15:0] = iSw;
                        state_next      = S_HI;
                    end
                end
                S_HI: begin
                    if (load_press) begin
                        data_next[31:16] = iSw;
                        state_next       = S_VALID;
                    end
                end
                S_VALID: begin
                    if (iAck) begin
                        state_next = S_LO;
                    end
                end
                default: begin
                    state_next = S_LO;
                end
            endcase
        end
    end

    assign oData  = data_reg;
    assign oValid = (state_reg == S_VALID);
    assign oHalf  = (state_reg == S_HI);

`ifdef INPUT_BLOCK_ECHO_EN
    logic [15:0] echo_reg;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            echo_reg <= '0;
        end else begin
            echo_reg <= (state_next == S_VALID) ? data_next[15:0] : iSw;
        end
    end

    assign oEcho = echo_reg;
`endif

endmodule

// File: tb/tb_input_block.sv
// Directed bench for input_block: table of button/ack operations plus bounce and reset sequences.
`timescale 1ns/1ps
module tb_input_block;

    logic        iClk;
    logic        iRstN;
    logic        iTick;
    logic [15:0] iSw;
    logic        iBLoad;
    logic        iBClr;
    logic        iAck;
    logic [31:0] oData;
    logic        oValid;
    logic        oHalf;
`ifdef INPUT_BLOCK_ECHO_EN
    logic [15:0] oEcho;
`endif

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    input_block #(
        .DB_TICKS(10)
    ) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iTick (iTick),
        .iSw   (iSw),
        .iBLoad(iBLoad),
        .iBClr (iBClr),
        .iAck  (iAck),
        .oData (oData),
        .oValid(oValid),
        .oHalf (oHalf)
`ifdef INPUT_BLOCK_ECHO_EN
        ,
        .oEcho (oEcho)
`endif
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // One tick every 4 clocks keeps the run short while exercising the same debounce counts.
    initial begin
        iTick = 1'b0;
        forever begin
            @(negedge iClk);
            iTick = (tick_cnt == 3);
            tick_cnt = (tick_cnt + 1) % 4;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef enum int {OP_LOAD, OP_CLR, OP_BOTH, OP_ACK} op_e;

    typedef struct {
        op_e         op;
        logic [15:0] sw;
        logic [31:0] data;
        logic        valid;
        logic        half;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge iClk);
            if (iTick) c++;
        end
        @(negedge iClk);
    endtask

    task automatic press(input logic load, input logic clr, input logic [15:0] sw);
        iSw    = sw;
        iBLoad = load;
        iBClr  = clr;
        wait_ticks(12);
        iBLoad = 1'b0;
        iBClr  = 1'b0;
        wait_ticks(12);
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] data, input logic valid,
                                 input logic half);
        check({tag, "_data"}, oData, data);
        check({tag, "_valid"}, 32'(oValid), 32'(valid));
        check({tag, "_half"}, 32'(oHalf), 32'(half));
`ifdef INPUT_BLOCK_ECHO_EN
        check({tag, "_echo"}, 32'(oEcho), 32'(valid ? data[15:0] : iSw));
`endif
    endtask

    initial begin
        logic        prev_valid;
        logic [31:0] prev_data;

        vecs[0]  = '{OP_LOAD, 16'h1234, 32'h0000_1234, 1'b0, 1'b1};
        vecs[1]  = '{OP_LOAD, 16'hABCD, 32'hABCD_1234, 1'b1, 1'b0};
        vecs[2]  = '{OP_LOAD, 16'hFFFF, 32'hABCD_1234, 1'b1, 1'b0};
        vecs[3]  = '{OP_ACK,  16'hFFFF, 32'hABCD_1234, 1'b0, 1'b0};
        vecs[4]  = '{OP_LOAD, 16'h00FF, 32'hABCD_00FF, 1'b0, 1'b1};
        vecs[5]  = '{OP_ACK,  16'h00FF, 32'hABCD_00FF, 1'b0, 1'b1};
        vecs[6]  = '{OP_BOTH, 16'h1111, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7]  = '{OP_LOAD, 16'h5A5A, 32'h0000_5A5A, 1'b0, 1'b1};
        vecs[8]  = '{OP_CLR,  16'h5A5A, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{OP_LOAD, 16'h0001, 32'h0000_0001, 1'b0, 1'b1};
        vecs[10] = '{OP_LOAD, 16'h8000, 32'h8000_0001, 1'b1, 1'b0};
        vecs[11] = '{OP_ACK,  16'h8000, 32'h8000_0001, 1'b0, 1'b0};

        iRstN  = 1'b0;
        iSw    = 16'h0000;
        iBLoad = 1'b0;
        iBClr  = 1'b0;
        iAck   = 1'b0;
        repeat (3) @(negedge iClk);
        check_outputs("reset", 32'h0, 1'b0, 1'b0);
        iRstN = 1'b1;
        @(negedge iClk);

        prev_valid = 1'b0;
        prev_data  = 32'h0;
        for (int i = 0; i < 12; i++) begin
            case (vecs[i].op)
                OP_LOAD: press(1'b1, 1'b0, vecs[i].sw);
                OP_CLR:  press(1'b0, 1'b1, vecs[i].sw);
                OP_BOTH: press(1'b1, 1'b1, vecs[i].sw);
                default: begin
                    iSw = vecs[i].sw;
                    repeat (50) @(negedge iClk);
                    check($sformatf("v%0d_hold_valid", i), 32'(oValid), 32'(prev_valid));
                    check($sformatf("v%0d_hold_data", i), oData, prev_data);
                    iAck = 1'b1;
                    @(negedge iClk);
                    iAck = 1'b0;
                    @(negedge iClk);
                end
            endcase
            $display("vec %0d op=%0d sw=%h data=%h valid=%b half=%b", i, vecs[i].op, iSw, oData,
                     oValid, oHalf);
            check_outputs($sformatf("v%0d", i), vecs[i].data, vecs[i].valid, vecs[i].half);
            prev_valid = vecs[i].valid;
            prev_data  = vecs[i].data;
        end

        // Bounce: three-tick pulses never reach the ten-tick threshold.
        iSw = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            iBLoad = (i % 2 == 0);
            wait_ticks(3);
        end
        $display("bounce done half=%b data=%h", oHalf, oData);
        check("bounce_half", 32'(oHalf), 32'h0);
        iBLoad = 1'b1;
        wait_ticks(8);
        check("stable8_half", 32'(oHalf), 32'h0);
        wait_ticks(4);
        check("stable12_half", 32'(oHalf), 32'h1);
        wait_ticks(20);
        $display("held load half=%b valid=%b data=%h", oHalf, oValid, oData);
        check("held_one_press_valid", 32'(oValid), 32'h0);
        check("held_one_press_half", 32'(oHalf), 32'h1);
        check("held_data", oData, 32'h8000_1234);
        iBLoad = 1'b0;
        wait_ticks(12);

        // Reset mid-entry discards the partial word at once.
        iRstN = 1'b0;
        #1;
        $display("reset mid-entry data=%h valid=%b half=%b", oData, oValid, oHalf);
        check("rst_mid_outputs", {oData[29:0], oValid, oHalf}, 32'h0);
        check("rst_mid_data_hi", 32'(oData[31:30]), 32'h0);
        @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);
        press(1'b1, 1'b0, 16'hBEEF);
        $display("post-reset load sw=beef data=%h half=%b", oData, oHalf);
        check_outputs("rst_lo", 32'h0000_BEEF, 1'b0, 1'b1);
        press(1'b1, 1'b0, 16'hCAFE);
        $display("post-reset load sw=cafe data=%h valid=%b", oData, oValid);
        check_outputs("rst_hi", 32'hCAFE_BEEF, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
